// File: rtl/mem_arbiter_pkg.sv
// Shared types for the RAM-port arbiter: word type, RAM status, arbiter state
// and the cache-to-requester index map.
// Ports: none (package).
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arbstate_t;

  // Each core owns two adjacent requester slots: data cache first, then instruction cache.
  localparam int REQS_PER_CORE = 2;

  function automatic int dcache_idx(input int k);
    return REQS_PER_CORE * k;
  endfunction

  function automatic int icache_idx(input int k);
    return REQS_PER_CORE * k + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: first set bit of pending at or after ptr, wrapping modulo NREQ.
// Ports: pending (request mask), ptr (search start) -> idx (winner), vld (any pending).
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            vld
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest pending index wins last.
  always_comb begin
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = IW'((int'(ptr) + off) % NREQ);
      if (pending[cand]) begin
        idx = cand;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port among NREQ cache requesters, one transaction at a time,
// round-robin with optional data-cache priority and a no-response watchdog.
// Ports: CLK/nRST; req_* per-requester request bus and wait/err/load returns;
//        ram* single RAM port (enables, address, store, load, status).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter bit DPRIO   = 1'b1,
  parameter int TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic  [NREQ-1:0]     req_ren,
  input  logic  [NREQ-1:0]     req_wen,
  input  word_t [NREQ-1:0]     req_addr,
  input  word_t [NREQ-1:0]     req_store,
  output word_t                req_load,
  output logic  [NREQ-1:0]     req_wait,
  output logic  [NREQ-1:0]     req_err,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  logic  [1:0]          ramstate
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen in the last allowed ISSUE cycle; that cycle becomes the error.
  localparam logic [TW-1:0] WD_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  function automatic logic [NREQ-1:0] dcache_mask();
    logic [NREQ-1:0] m;
    m = '0;
    for (int k = 0; k < NREQ / 2; k++) m = m | (NREQ'(1) << dcache_idx(k));
    return m;
  endfunction

  localparam logic [NREQ-1:0] DMASK = dcache_mask();

  arbstate_t       state, state_nx;
  logic [IW-1:0]   grant, grant_nx;
  logic [IW-1:0]   rr_ptr, rr_ptr_nx;
  logic [TW-1:0]   wdog, wdog_nx;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] done_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic            g_ren, g_wen, done;
  ramstate_t       rs;

  assign pending = req_ren | req_wen;
  assign rs      = ramstate_t'(ramstate);
  assign g_ren   = req_ren[grant];
  assign g_wen   = req_wen[grant];

  generate
    if (DPRIO) begin : g_prio
      logic [IW-1:0] d_idx, i_idx;
      logic          d_vld, i_vld;
      rr_pick #(.NREQ(NREQ)) u_dpick (
        .pending (pending & DMASK),
        .ptr     (rr_ptr),
        .idx     (d_idx),
        .vld     (d_vld)
      );
      rr_pick #(.NREQ(NREQ)) u_ipick (
        .pending (pending & ~DMASK),
        .ptr     (rr_ptr),
        .idx     (i_idx),
        .vld     (i_vld)
      );
      assign pick_idx = d_vld ? d_idx : i_idx;
      assign pick_vld = d_vld | i_vld;
    end else begin : g_flat
      rr_pick #(.NREQ(NREQ)) u_pick (
        .pending (pending),
        .ptr     (rr_ptr),
        .idx     (pick_idx),
        .vld     (pick_vld)
      );
    end
  endgenerate

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      wdog   <= '0;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      rr_ptr <= rr_ptr_nx;
      wdog   <= wdog_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    rr_ptr_nx = rr_ptr;
    wdog_nx   = wdog;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    req_load  = '0;
    req_err   = '0;
    done      = 1'b0;
    done_oh   = '0;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nx = ISSUE;
          grant_nx = pick_idx;
          wdog_nx  = '0;
        end
      end
      ISSUE: begin
        if (!(g_ren | g_wen)) begin
          // Requester abandoned the access: release without completing or advancing.
          state_nx = IDLE;
          wdog_nx  = '0;
        end else begin
          ramREN   = g_ren & ~g_wen;
          ramWEN   = g_wen;
          ramaddr  = req_addr[grant];
          ramstore = req_store[grant];
          if (rs == ACCESS) begin
            done = 1'b1;
            if (!g_wen) req_load = ramload;
          end else if (rs == ERROR || (TIMEOUT > 0 && wdog == WD_LAST)) begin
            done           = 1'b1;
            req_err[grant] = 1'b1;
          end
          if (done) begin
            done_oh[grant] = 1'b1;
            state_nx       = IDLE;
            rr_ptr_nx      = (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);
            wdog_nx        = '0;
          end else begin
            wdog_nx = wdog + TW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign req_wait = pending & ~done_oh;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [3:0]       req_ren, req_wen;
  logic [3:0][31:0] req_addr, req_store;
  logic [31:0]      ramload;
  logic [1:0]       ramstate;

  logic [31:0] p_load, p_addr, p_store, r_load, r_addr, r_store;
  logic [3:0]  p_wait, p_err, r_wait, r_err;
  logic        p_ren, p_wen, r_ren, r_wen;
  logic [105:0] p_obs, r_obs;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.NREQ(4), .DPRIO(1'b1), .TIMEOUT(5)) u_prio (
    .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_store(req_store), .req_load(p_load),
    .req_wait(p_wait), .req_err(p_err), .ramREN(p_ren), .ramWEN(p_wen),
    .ramaddr(p_addr), .ramstore(p_store), .ramload(ramload), .ramstate(ramstate)
  );

  mem_arbiter #(.NREQ(4), .DPRIO(1'b0), .TIMEOUT(255)) u_rr (
    .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_store(req_store), .req_load(r_load),
    .req_wait(r_wait), .req_err(r_err), .ramREN(r_ren), .ramWEN(r_wen),
    .ramaddr(r_addr), .ramstore(r_store), .ramload(ramload), .ramstate(ramstate)
  );

  assign p_obs = {p_ren, p_wen, p_wait, p_err, p_addr, p_store, p_load};
  assign r_obs = {r_ren, r_wen, r_wait, r_err, r_addr, r_store, r_load};

  // Expected observation vector: {ramREN, ramWEN, req_wait, req_err, ramaddr, ramstore, req_load}
  function automatic logic [105:0] pk(input logic r, input logic w, input logic [3:0] wt,
                                      input logic [3:0] er, input logic [31:0] a,
                                      input logic [31:0] s, input logic [31:0] l);
    return {r, w, wt, er, a, s, l};
  endfunction

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    req_ren   = '0;
    req_wen   = '0;
    req_addr  = '0;
    req_store = '0;
    ramload   = '0;
    ramstate  = FREE;
    nRST      = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic test_reset();
    logic [105:0] exp;
    apply_reset();
    nRST = 1'b0;
    req_ren[2] = 1'b1;
    req_addr[2] = 32'h0000_0080;
    ramstate = ACCESS;
    ramload = 32'hFFFF_FFFF;
    #1;
    exp = pk(0, 0, 4'b0100, 4'b0000, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL reset_prio: got %h want %h", p_obs, exp); end
    n_checks++;
    if (r_obs !== exp) begin n_fails++; $display("FAIL reset_rr: got %h want %h", r_obs, exp); end
    next_cycle();
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL reset_hold_prio: got %h want %h", p_obs, exp); end
    n_checks++;
    if (r_obs !== exp) begin n_fails++; $display("FAIL reset_hold_rr: got %h want %h", r_obs, exp); end
  endtask

  task automatic test_single_read();
    logic [105:0] exp;
    apply_reset();
    req_ren[1] = 1'b1;
    req_addr[1] = 32'h0000_0040;
    ramstate = BUSY;
    ramload = 32'hDEAD_BEEF;
    #1;
    exp = pk(0, 0, 4'b0010, 4'b0000, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL read_arb: got %h want %h", p_obs, exp); end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      #1;
      exp = pk(1, 0, 4'b0010, 4'b0000, 32'h40, 32'h0, 32'h0);
      n_checks++;
      if (p_obs !== exp) begin n_fails++; $display("FAIL read_busy_c%0d: got %h want %h", c, p_obs, exp); end
    end
    next_cycle();
    ramstate = ACCESS;
    #1;
    exp = pk(1, 0, 4'b0000, 4'b0000, 32'h40, 32'h0, 32'hDEAD_BEEF);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL read_access: got %h want %h", p_obs, exp); end
    next_cycle();
    req_ren[1] = 1'b0;
    ramstate = FREE;
    #1;
    exp = pk(0, 0, 4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL read_idle_after: got %h want %h", p_obs, exp); end
  endtask

  task automatic test_priority();
    logic [105:0] exp;
    apply_reset();
    req_ren[1] = 1'b1;
    req_addr[1] = 32'h0000_0104;
    req_wen[2] = 1'b1;
    req_addr[2] = 32'h0000_0108;
    req_store[2] = 32'hA5A5_0000;
    ramstate = ACCESS;
    ramload = 32'h1111_2222;
    #1;
    exp = pk(0, 0, 4'b0110, 4'b0000, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL prio_arb: got %h want %h", p_obs, exp); end
    next_cycle();
    #1;
    exp = pk(0, 1, 4'b0010, 4'b0000, 32'h108, 32'hA5A5_0000, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL prio_dcache_first: got %h want %h", p_obs, exp); end
    exp = pk(1, 0, 4'b0100, 4'b0000, 32'h104, 32'h0, 32'h1111_2222);
    n_checks++;
    if (r_obs !== exp) begin n_fails++; $display("FAIL noprio_rr_first: got %h want %h", r_obs, exp); end
    next_cycle();
    req_wen[2] = 1'b0;
    #1;
    exp = pk(0, 0, 4'b0010, 4'b0000, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL prio_bubble: got %h want %h", p_obs, exp); end
    next_cycle();
    #1;
    exp = pk(1, 0, 4'b0000, 4'b0000, 32'h104, 32'h0, 32'h1111_2222);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL prio_icache_second: got %h want %h", p_obs, exp); end
  endtask

  task automatic test_round_robin();
    logic [105:0] exp;
    int r_order[5] = '{0, 1, 2, 3, 0};
    int p_order[3] = '{0, 2, 0};
    apply_reset();
    req_ren = 4'hF;
    for (int i = 0; i < 4; i++) req_addr[i] = 32'h200 + 32'(4 * i);
    ramstate = ACCESS;
    ramload = 32'hCAFE_0000;
    #1;
    for (int s = 0; s < 5; s++) begin
      next_cycle();
      #1;
      exp = pk(1, 0, 4'hF & ~(4'b0001 << r_order[s]), 4'b0000,
               32'h200 + 32'(4 * r_order[s]), 32'h0, 32'hCAFE_0000);
      n_checks++;
      if (r_obs !== exp) begin n_fails++; $display("FAIL rr_slot%0d: got %h want %h", s, r_obs, exp); end
      if (s < 3) begin
        exp = pk(1, 0, 4'hF & ~(4'b0001 << p_order[s]), 4'b0000,
                 32'h200 + 32'(4 * p_order[s]), 32'h0, 32'hCAFE_0000);
        n_checks++;
        if (p_obs !== exp) begin n_fails++; $display("FAIL prio_rr_slot%0d: got %h want %h", s, p_obs, exp); end
      end
      next_cycle();
      #1;
      exp = pk(0, 0, 4'hF, 4'b0000, 32'h0, 32'h0, 32'h0);
      n_checks++;
      if (r_obs !== exp) begin n_fails++; $display("FAIL rr_bubble%0d: got %h want %h", s, r_obs, exp); end
    end
  endtask

  task automatic test_rw_conflict();
    logic [105:0] exp;
    apply_reset();
    req_ren[2] = 1'b1;
    req_wen[2] = 1'b1;
    req_addr[2] = 32'h0000_0080;
    req_store[2] = 32'h0000_1234;
    ramstate = BUSY;
    ramload = 32'hFFFF_0000;
    next_cycle();
    #1;
    exp = pk(0, 1, 4'b0100, 4'b0000, 32'h80, 32'h1234, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL rw_busy: got %h want %h", p_obs, exp); end
    next_cycle();
    ramstate = ACCESS;
    #1;
    exp = pk(0, 1, 4'b0000, 4'b0000, 32'h80, 32'h1234, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL rw_complete_noload: got %h want %h", p_obs, exp); end
    n_checks++;
    if (r_obs !== exp) begin n_fails++; $display("FAIL rw_complete_rr: got %h want %h", r_obs, exp); end
  endtask

  task automatic test_watchdog();
    logic [105:0] exp;
    apply_reset();
    req_ren[3] = 1'b1;
    req_addr[3] = 32'h0000_00C0;
    req_addr[1] = 32'h0000_0044;
    ramstate = BUSY;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c == 2) req_ren[1] = 1'b1;
      #1;
      exp = pk(1, 0, (c >= 2) ? 4'b1010 : 4'b1000, 4'b0000, 32'hC0, 32'h0, 32'h0);
      n_checks++;
      if (p_obs !== exp) begin n_fails++; $display("FAIL wd_busy_c%0d: got %h want %h", c, p_obs, exp); end
    end
    next_cycle();
    #1;
    exp = pk(1, 0, 4'b0010, 4'b1000, 32'hC0, 32'h0, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL wd_timeout_pulse: got %h want %h", p_obs, exp); end
    next_cycle();
    req_ren[3] = 1'b0;
    #1;
    exp = pk(0, 0, 4'b0010, 4'b0000, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL wd_release: got %h want %h", p_obs, exp); end
    next_cycle();
    #1;
    exp = pk(1, 0, 4'b0010, 4'b0000, 32'h44, 32'h0, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL wd_next_grant: got %h want %h", p_obs, exp); end
  endtask

  task automatic test_ram_error();
    logic [105:0] exp;
    apply_reset();
    req_ren[1] = 1'b1;
    req_addr[0] = 32'h0000_0010;
    req_addr[1] = 32'h0000_0044;
    req_addr[2] = 32'h0000_0020;
    ramstate = ERROR;
    ramload = 32'h5555_5555;
    next_cycle();
    #1;
    exp = pk(1, 0, 4'b0000, 4'b0010, 32'h44, 32'h0, 32'h0);
    n_checks++;
    if (r_obs !== exp) begin n_fails++; $display("FAIL err_pulse: got %h want %h", r_obs, exp); end
    next_cycle();
    req_ren = 4'b0101;
    ramstate = BUSY;
    #1;
    exp = pk(0, 0, 4'b0101, 4'b0000, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (r_obs !== exp) begin n_fails++; $display("FAIL err_single_cycle: got %h want %h", r_obs, exp); end
    next_cycle();
    #1;
    exp = pk(1, 0, 4'b0101, 4'b0000, 32'h20, 32'h0, 32'h0);
    n_checks++;
    if (r_obs !== exp) begin n_fails++; $display("FAIL err_ptr_advanced: got %h want %h", r_obs, exp); end
  endtask

  task automatic test_abort();
    logic [105:0] exp;
    apply_reset();
    req_ren[0] = 1'b1;
    req_addr[0] = 32'h0000_0010;
    req_addr[2] = 32'h0000_0020;
    ramstate = BUSY;
    next_cycle();
    #1;
    exp = pk(1, 0, 4'b0001, 4'b0000, 32'h10, 32'h0, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL abort_issue: got %h want %h", p_obs, exp); end
    next_cycle();
    req_ren[0] = 1'b0;
    #1;
    exp = pk(0, 0, 4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL abort_same_cycle: got %h want %h", p_obs, exp); end
    next_cycle();
    req_ren = 4'b0101;
    next_cycle();
    #1;
    exp = pk(1, 0, 4'b0101, 4'b0000, 32'h10, 32'h0, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL abort_ptr_kept_prio: got %h want %h", p_obs, exp); end
    n_checks++;
    if (r_obs !== exp) begin n_fails++; $display("FAIL abort_ptr_kept_rr: got %h want %h", r_obs, exp); end
  endtask

  task automatic test_reset_mid_issue();
    logic [105:0] exp;
    apply_reset();
    req_ren[0] = 1'b1;
    req_addr[0] = 32'h0000_0010;
    ramstate = BUSY;
    next_cycle();
    #1;
    exp = pk(1, 0, 4'b0001, 4'b0000, 32'h10, 32'h0, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL rstmid_issue: got %h want %h", p_obs, exp); end
    ramstate = ERROR;
    nRST = 1'b0;
    #1;
    exp = pk(0, 0, 4'b0001, 4'b0000, 32'h0, 32'h0, 32'h0);
    n_checks++;
    if (p_obs !== exp) begin n_fails++; $display("FAIL rstmid_immediate: got %h want %h", p_obs, exp); end
    next_cycle();
    n_checks++;
    if (r_obs !== exp) begin n_fails++; $display("FAIL rstmid_hold_rr: got %h want %h", r_obs, exp); end
    nRST = 1'b1;
  endtask

  initial begin
    nRST      = 1'b0;
    req_ren   = '0;
    req_wen   = '0;
    req_addr  = '0;
    req_store = '0;
    ramload   = '0;
    ramstate  = FREE;
    test_reset();
    test_single_read();
    test_priority();
    test_round_robin();
    test_rw_conflict();
    test_watchdog();
    test_ram_error();
    test_abort();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port among NREQ cache-side requesters: the instruction and data caches of one or more cores.
- Requester index map: core k data cache = 2k; core k instruction cache = 2k+1.
- Holds one transaction at a time and locks the grant until the transaction completes or is abandoned.
- Selects the next requester round-robin, with optional data-cache priority. A watchdog releases the port if the RAM never responds.

Parameters:
- NREQ, 4, number of requesters (even, ≥2).
- DPRIO, 1, when 1 any pending even-index (data cache) request beats every odd-index request; round-robin applies within each class.
- TIMEOUT, 255, maximum cycles in ISSUE before forced release; 0 disables the watchdog.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; asynchronous, active-low
- req_ren  in  NREQ  per-requester read request
- req_wen  in  NREQ  per-requester write request
- req_addr  in  NREQ×32  per-requester word address
- req_store  in  NREQ×32  per-requester write data
- req_load  out  32  read data, shared; valid only for the completing requester
- req_wait  out  NREQ  per-requester stall
- req_err  out  NREQ  one-cycle error/timeout pulse
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Request definition: pending[i] = req_ren[i] | req_wen[i]. If both are set, the access is a write and ren is ignored.
- States: IDLE, ISSUE.
- IDLE:
  - RAM outputs: ramREN=ramWEN=0, ramaddr=0, ramstore=0.
  - If any request is pending, the pick is latched into grant and the state moves to ISSUE on the next edge.
  - With nothing pending, the state stays IDLE.
- Pick rule:
  - DPRIO=1: use the even-index pending set if it is non-empty, otherwise the odd-index set.
  - Within the chosen set, take the first pending index at or after rr_ptr, with wrap-around modulo NREQ.
- ISSUE, RAM drive:
  - ramREN = req_ren[grant] & ~req_wen[grant]; ramWEN = req_wen[grant].
  - ramaddr and ramstore come combinationally from the granted requester.
- ISSUE, completion:
  - ramstate==ACCESS: req_wait[grant]=0 and req_load=ramload in that same cycle; next state IDLE; rr_ptr ← grant+1 mod NREQ.
  - ramstate==ERROR: req_err[grant]=1 and req_wait[grant]=0 for one cycle; next state IDLE; rr_ptr advances.
  - The granted requester dropping both ren and wen while in ISSUE (abort): next state IDLE, no completion, rr_ptr unchanged, RAM enables deassert in the same cycle.
- Watchdog:
  - Counter cleared on entry to ISSUE and incremented each ISSUE cycle that is not ACCESS.
  - On reaching TIMEOUT (non-zero), treat the cycle as ERROR.
  - Counter width is the bits needed to hold TIMEOUT.
- req_wait[i] = pending[i] & ~(state==ISSUE & grant==i & completing). Non-pending requesters see wait=0.
- req_load = ramload when completing a read; 0 otherwise.
- Latency: minimum 2 cycles from request to completion (1 arbitration + 1 RAM). There is one IDLE bubble between back-to-back transactions.
- Requester obligation: addr, store and type stay stable while wait=1. Any change other than a full drop is undefined.
- Reset, asynchronous: state=IDLE, grant=0, rr_ptr=0, watchdog=0. All outputs are 0 except req_wait, which follows pending combinationally. Reset during ISSUE abandons the transaction with no err pulse.

Decomposition:
- Existing shared cpu package supplies word_t and ramstate_t (FREE/BUSY/ACCESS/ERROR).
- New shared additions: arbstate_t enum {IDLE, ISSUE} and a constant for the requester index map (DCACHE(k)=2k, ICACHE(k)=2k+1).
- One sub-module, rr_pick: parameterised NREQ; inputs pending mask and pointer; outputs index and valid. It is instantiated twice (even/odd classes) when DPRIO=1.

Test Plan:
- Single read: req_ren[1]=1, addr 0x40. RAM returns BUSY×3 then ACCESS with 0xDEADBEEF → ramREN high cycles 1–4, req_wait[1] low only in cycle 4, req_load=0xDEADBEEF, state IDLE in cycle 5.
- Data-cache priority: req_ren[1] and req_wen[0] raised together, RAM ACCESS immediately → requester 0 served first (ramWEN, its store data), requester 1 served in cycles 3–4.
- Round-robin: all four issue reads, RAM always ACCESS, DPRIO=0 → service order 0,1,2,3,0; each completion 2 cycles apart.
- Read+write conflict: req_ren[2]=req_wen[2]=1, addr 0x80, store 0x1234 → ramWEN=1, ramREN=0, ramstore=0x1234.
- Watchdog: TIMEOUT=5, RAM held BUSY → req_err[3] single pulse in the fifth ISSUE cycle, wait drops, arbiter returns to IDLE and next pending request is granted.
- Abort and reset: requester 0 drops ren mid-ISSUE → RAM enables low the same cycle, rr_ptr unchanged. nRST asserted during ISSUE → all RAM outputs 0 immediately, no err pulse.
